// File: rtl/ccff_mux_loader.sv
// Loads one-hot mux select patterns into the configuration flip-flop chain from a valid/ready index stream.
// Optional CCFF_READBACK_EN adds a recirculating verify pass that flags groups with two or more ones.
module ccff_mux_loader #(
    parameter int NUM_MUX = 8,
    parameter int MEM_W   = 4,
    parameter int IDX_W   = 3
) (
    input  logic             prog_clk,
    input  logic             prog_reset,
    input  logic             sel_valid,
    output logic             sel_ready,
    input  logic [IDX_W-1:0] sel_idx,
    input  logic             sel_last,
    output logic             ccff_head,
    input  logic             ccff_tail,
    output logic             chain_shift_en,
    output logic             busy,
    output logic             done,
    output logic             err_idx,
    output logic             err_count,
    output logic             err_onehot
);

    localparam int CHAIN_L = NUM_MUX * MEM_W;
    localparam int BIT_W   = (MEM_W > 1) ? $clog2(MEM_W) : 1;
    localparam int WORD_W  = $clog2(NUM_MUX + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT,
        ST_VERIFY,
        ST_DONE
    } state_t;

    state_t              state_q;
    logic [MEM_W-1:0]    shreg_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [WORD_W-1:0]   word_cnt_q;
    logic                last_q;
    logic                sel_ready_q;
    logic                head_q;
    logic                shift_en_q;
    logic                busy_q;
    logic                done_q;
    logic                err_idx_q;
    logic                err_count_q;

    logic                accept;
    logic                idx_bad;
    logic                bit_final;
    logic [BIT_W-1:0]    bit_inc;
    logic [WORD_W-1:0]   word_inc;
    logic [MEM_W-1:0]    pat;
    logic [MEM_W-1:0]    shreg_nx;

    function automatic logic [MEM_W-1:0] encode(input logic [IDX_W-1:0] idx);
        logic [MEM_W-1:0] p;
        p = '0;
        for (int i = 0; i < MEM_W; i++) begin
            if (idx == IDX_W'(i)) p[i] = 1'b1;
        end
        return p;
    endfunction

    assign accept    = sel_valid && sel_ready_q;
    assign idx_bad   = sel_idx > IDX_W'(MEM_W);
    assign pat       = encode(sel_idx);
    assign shreg_nx  = shreg_q << 1;
    assign bit_inc   = bit_cnt_q + 1'b1;
    assign bit_final = bit_cnt_q == BIT_W'(MEM_W - 1);
    // Counts one past NUM_MUX so an overlong load still mismatches at sel_last.
    assign word_inc  = (word_cnt_q == WORD_W'(NUM_MUX + 1)) ? word_cnt_q : word_cnt_q + 1'b1;

`ifdef CCFF_READBACK_EN
    localparam int VER_W = (CHAIN_L > 1) ? $clog2(CHAIN_L) : 1;

    logic [VER_W-1:0]    ver_cnt_q;
    logic [1:0]          ones_q;
    logic [1:0]          ones_nx;
    logic                err_onehot_q;

    assign ones_nx    = ones_q[1] ? 2'd2 : ones_q + {1'b0, ccff_tail};
    assign ccff_head  = (state_q == ST_VERIFY) ? ccff_tail : head_q;
    assign err_onehot = err_onehot_q;
`else
    logic                unused_tail;

    assign unused_tail = ccff_tail;
    assign ccff_head   = head_q;
    assign err_onehot  = 1'b0;
`endif

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            last_q       <= 1'b0;
            sel_ready_q  <= 1'b1;
            head_q       <= 1'b0;
            shift_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_idx_q    <= 1'b0;
            err_count_q  <= 1'b0;
`ifdef CCFF_READBACK_EN
            ver_cnt_q    <= '0;
            ones_q       <= '0;
            err_onehot_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                // Only possible in IDLE, WAIT or the final bit cycle of SHIFT.
                state_q     <= ST_SHIFT;
                shreg_q     <= pat;
                head_q      <= pat[MEM_W-1];
                shift_en_q  <= 1'b1;
                busy_q      <= 1'b1;
                bit_cnt_q   <= '0;
                last_q      <= sel_last;
                sel_ready_q <= (MEM_W == 1) && !sel_last;
                if (state_q == ST_IDLE) begin
                    word_cnt_q   <= WORD_W'(1);
                    err_idx_q    <= idx_bad;
                    err_count_q  <= 1'b0;
`ifdef CCFF_READBACK_EN
                    err_onehot_q <= 1'b0;
`endif
                end else begin
                    word_cnt_q <= word_inc;
                    if (idx_bad) err_idx_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE, ST_WAIT: begin
                        sel_ready_q <= 1'b1;
                    end
                    ST_SHIFT: begin
                        if (!bit_final) begin
                            shreg_q     <= shreg_nx;
                            head_q      <= shreg_nx[MEM_W-1];
                            bit_cnt_q   <= bit_inc;
                            sel_ready_q <= (bit_inc == BIT_W'(MEM_W - 1)) && !last_q;
                        end else if (last_q) begin
                            head_q      <= 1'b0;
                            sel_ready_q <= 1'b0;
                            if (word_cnt_q != WORD_W'(NUM_MUX)) err_count_q <= 1'b1;
`ifdef CCFF_READBACK_EN
                            state_q    <= ST_VERIFY;
                            shift_en_q <= 1'b1;
                            ver_cnt_q  <= '0;
                            bit_cnt_q  <= '0;
                            ones_q     <= '0;
`else
                            state_q    <= ST_DONE;
                            shift_en_q <= 1'b0;
                            done_q     <= 1'b1;
`endif
                        end else begin
                            state_q     <= ST_WAIT;
                            head_q      <= 1'b0;
                            shift_en_q  <= 1'b0;
                            sel_ready_q <= 1'b1;
                        end
                    end
`ifdef CCFF_READBACK_EN
                    ST_VERIFY: begin
                        bit_cnt_q <= bit_final ? '0 : bit_inc;
                        ones_q    <= bit_final ? 2'd0 : ones_nx;
                        if (bit_final && ones_nx[1]) err_onehot_q <= 1'b1;
                        if (ver_cnt_q == VER_W'(CHAIN_L - 1)) begin
                            state_q    <= ST_DONE;
                            shift_en_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            ver_cnt_q <= ver_cnt_q + 1'b1;
                        end
                    end
`endif
                    ST_DONE: begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        sel_ready_q <= 1'b1;
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        head_q      <= 1'b0;
                        shift_en_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        sel_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign sel_ready      = sel_ready_q;
    assign chain_shift_en = shift_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_idx        = err_idx_q;
    assign err_count      = err_count_q;

endmodule

// File: tb/tb_ccff_mux_loader.sv
// Directed bench for ccff_mux_loader with a behavioural model of the 32-flop configuration chain.
module tb_ccff_mux_loader;
    localparam int NUM_MUX = 8;
    localparam int MEM_W   = 4;
    localparam int IDX_W   = 3;
    localparam int L       = NUM_MUX * MEM_W;
`ifdef CCFF_READBACK_EN
    localparam int RB = L;
`else
    localparam int RB = 0;
`endif

    logic             prog_clk   = 1'b0;
    logic             prog_reset = 1'b1;
    logic             sel_valid  = 1'b0;
    logic             sel_last   = 1'b0;
    logic [IDX_W-1:0] sel_idx    = '0;
    logic             sel_ready, ccff_head, ccff_tail, chain_shift_en;
    logic             busy, done, err_idx, err_count, err_onehot;

    logic [L-1:0]     chain       = '0;
    logic             corrupt_req = 1'b0;
    logic [IDX_W-1:0] idx_tab [NUM_MUX];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_mux_loader #(.NUM_MUX(NUM_MUX), .MEM_W(MEM_W), .IDX_W(IDX_W)) dut (
        .prog_clk       (prog_clk),
        .prog_reset     (prog_reset),
        .sel_valid      (sel_valid),
        .sel_ready      (sel_ready),
        .sel_idx        (sel_idx),
        .sel_last       (sel_last),
        .ccff_head      (ccff_head),
        .ccff_tail      (ccff_tail),
        .chain_shift_en (chain_shift_en),
        .busy           (busy),
        .done           (done),
        .err_idx        (err_idx),
        .err_count      (err_count),
        .err_onehot     (err_onehot)
    );

    // Chain model: first bit shifted ends deepest; group g sits at chain[L-1-g*MEM_W -: MEM_W].
    assign ccff_tail = chain[L-1];
    always @(posedge prog_clk) begin
        logic [L-1:0] nxt;
        nxt = chain;
        if (chain_shift_en) nxt = {chain[L-2:0], ccff_head};
        if (corrupt_req) nxt[L-1-2*MEM_W -: MEM_W] = 4'b0110;
        chain <= nxt;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Streams idx_tab[0..n-1], sel_last on word n. After stall_w words the host drops valid
    // for MEM_W+2 cycles. Cycle 0 is the first accept cycle.
    task automatic do_load(input int n, input int stall_w, input int corrupt_cyc,
                           output int nshift, output int done_cyc, output int nwait,
                           output logic [31:0] heads, output logic e1);
        int w, cyc, gap, nh;
        logic acc;
        w = 0; cyc = 0; gap = 0; nh = 0;
        nshift = 0; nwait = 0; done_cyc = -1; heads = '0; e1 = 1'b0;
        sel_idx   = idx_tab[0];
        sel_last  = (n == 1);
        sel_valid = 1'b1;
        for (int k = 0; k < 400 && done_cyc < 0; k++) begin
            acc = sel_valid && sel_ready;
            @(posedge prog_clk); #1;
            cyc++;
            corrupt_req = (cyc == corrupt_cyc);
            if (acc) begin
                w++;
                if (w == n) begin
                    sel_valid = 1'b0;
                    sel_last  = 1'b0;
                end else begin
                    sel_idx  = idx_tab[w];
                    sel_last = (w == n - 1);
                    if (w == stall_w) begin
                        sel_valid = 1'b0;
                        gap = MEM_W + 2;
                    end
                end
            end else if (gap > 0) begin
                gap--;
                if (gap == 0) sel_valid = 1'b1;
            end
            if (chain_shift_en) begin
                nshift++;
                if (nh < n * MEM_W) begin
                    heads = {heads[30:0], ccff_head};
                    nh++;
                end
            end
            if (busy && !chain_shift_en && !done) nwait++;
            if (cyc == 1) e1 = err_idx;
            if (done) done_cyc = cyc;
        end
        corrupt_req = 1'b0;
        @(posedge prog_clk); #1;
    endtask

    initial begin
        int ns, dc, nw, cnt;
        logic [31:0] hs;
        logic e1;

        idx_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};
        repeat (3) @(posedge prog_clk);
        #1;
        chk("rst_ready", {31'd0, sel_ready}, 32'd1);
        chk("rst_ctrl", {27'd0, busy, done, chain_shift_en, ccff_head, 1'b0}, 32'd0);
        chk("rst_err", {29'd0, err_idx, err_count, err_onehot}, 32'd0);
        prog_reset = 1'b0;
        @(posedge prog_clk); #1;

        // Contiguous 8-word load
        do_load(8, 0, -1, ns, dc, nw, hs, e1);
        chk("t1_done_cyc", dc, 33 + RB);
        chk("t1_shifts", ns, 32 + RB);
        chk("t1_wait", nw, 0);
        chk("t1_heads", hs, 32'h12480124);
        chk("t1_chain", chain, 32'h12480124);
        chk("t1_err", {29'd0, err_idx, err_count, err_onehot}, 32'd0);
        chk("t1_idle", {30'd0, sel_ready, busy}, 32'd2);

        // Host stall after word 2: three WAIT cycles
        do_load(8, 2, -1, ns, dc, nw, hs, e1);
        chk("t2_done_cyc", dc, 36 + RB);
        chk("t2_wait", nw, 3);
        chk("t2_shifts", ns, 32 + RB);
        chk("t2_chain", chain, 32'h12480124);

        // Out-of-range index in word 5
        idx_tab[4] = 3'd6;
        do_load(8, 0, -1, ns, dc, nw, hs, e1);
        chk("t3_done_cyc", dc, 33 + RB);
        chk("t3_chain", chain, 32'h12480124);
        chk("t3_err_idx", {31'd0, err_idx}, 32'd1);
        chk("t3_err_count", {31'd0, err_count}, 32'd0);
        chk("t3_sticky", {31'd0, err_idx}, 32'd1);
        idx_tab[4] = 3'd4;

        // Short load: sel_last on word 6
        do_load(6, 0, -1, ns, dc, nw, hs, e1);
        chk("t4_err_idx_clr", {31'd0, e1}, 32'd0);
        chk("t4_done_cyc", dc, 25 + RB);
        chk("t4_shifts", ns, 24 + RB);
        chk("t4_heads", hs, 32'h00124801);
        chk("t4_chain", {8'd0, chain[23:0]}, 32'h00124801);
        chk("t4_err_count", {31'd0, err_count}, 32'd1);
        chk("t4_err_idx", {31'd0, err_idx}, 32'd0);

        // Single-word load with the largest index
        idx_tab[0] = 3'd7;
        do_load(1, 0, -1, ns, dc, nw, hs, e1);
        chk("t5_done_cyc", dc, 5 + RB);
        chk("t5_grp", {28'd0, chain[3:0]}, 32'd0);
        chk("t5_err", {30'd0, err_idx, err_count}, 32'd3);
        idx_tab[0] = 3'd0;

`ifdef CCFF_READBACK_EN
        // Corrupt group 2 to 0110 just before VERIFY
        do_load(8, 0, 32, ns, dc, nw, hs, e1);
        chk("t6_done_cyc", dc, 65);
        chk("t6_onehot", {31'd0, err_onehot}, 32'd1);
        chk("t6_chain", chain, 32'h12680124);
        chk("t6_err_other", {30'd0, err_idx, err_count}, 32'd0);
`endif

        // Reset during shift cycle 10
        sel_idx   = idx_tab[0];
        sel_last  = 1'b0;
        sel_valid = 1'b1;
        cnt = 0;
        for (int k = 0; k < 60 && cnt < 10; k++) begin
            @(posedge prog_clk); #1;
            if (chain_shift_en) cnt++;
        end
        chk("t7_reach", cnt, 10);
        chk("t7_busy_pre", {31'd0, busy}, 32'd1);
        prog_reset = 1'b1;
        sel_valid  = 1'b0;
        @(posedge prog_clk); #1;
        prog_reset = 1'b0;
        chk("t7_rst_ctrl", {28'd0, busy, chain_shift_en, done, ccff_head}, 32'd0);
        chk("t7_rst_ready", {31'd0, sel_ready}, 32'd1);
        @(posedge prog_clk); #1;
        chk("t7_stay_idle", {30'd0, busy, chain_shift_en}, 32'd0);

        do_load(8, 0, -1, ns, dc, nw, hs, e1);
        chk("t7_done_cyc", dc, 33 + RB);
        chk("t7_chain", chain, 32'h12480124);
        chk("t7_err", {29'd0, err_idx, err_count, err_onehot}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
